// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the shared single-port memory.
// The arbiter connects through the slave modport; the environment uses the master modport.
interface mem_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 10
);
  // fetch port
  logic             imem_req;
  logic [ADDR-1:0]  imem_addr;
  logic             imem_gnt;
  logic             imem_valid;
  logic [WIDTH-1:0] imem_rdata;

  // data port
  logic             dmem_req;
  logic [3:0]       dmem_wr_en;
  logic [ADDR-1:0]  dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic             dmem_gnt;
  logic             dmem_valid;
  logic [WIDTH-1:0] dmem_rdata;

  // shared memory
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic             busy;

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_valid, imem_rdata,
    input  dmem_req, dmem_wr_en, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_valid, dmem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_valid, imem_rdata,
    output dmem_req, dmem_wr_en, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_valid, dmem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between a fetch and a data requester: data has priority,
// but a fetch denied STARVE_MAX consecutive cycles is forced through. Responses arrive 1 cycle after grant.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR       = 10,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     owner_reg, owner_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       force_i;
  logic       imem_gnt, dmem_gnt;

  assign force_i = (starve_cnt_reg == STARVE_LIM);

  // Grant, memory strobe and owner/starvation next-state; grants are suppressed during reset.
  always_comb begin
    imem_gnt        = 1'b0;
    dmem_gnt        = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 4'b0000;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    owner_next      = OWN_NONE;
    starve_cnt_next = 4'd0;

    if (!reset) begin
      dmem_gnt = bus.dmem_req && !force_i;
      imem_gnt = bus.imem_req && (!bus.dmem_req || force_i);
    end

    if (dmem_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dmem_wr_en;
      bus.mem_addr  = bus.dmem_addr;
      bus.mem_wdata = bus.dmem_wdata;
      owner_next    = OWN_DMEM;
    end else if (imem_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.imem_addr;
      owner_next    = OWN_IMEM;
    end

    if (bus.imem_req && !imem_gnt) begin
      starve_cnt_next = force_i ? starve_cnt_reg : starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= 4'd0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign bus.imem_gnt = imem_gnt;
  assign bus.dmem_gnt = dmem_gnt;
  assign bus.busy     = (owner_reg != OWN_NONE);

  // Index 0 is the fetch response channel, index 1 the data response channel.
  logic [1:0]       resp_valid;
  logic [WIDTH-1:0] resp_data [2];

  assign resp_valid[0] = (owner_reg == OWN_IMEM);
  assign resp_valid[1] = (owner_reg == OWN_DMEM);

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic [WIDTH-1:0] hold_reg;

    // Remembers the last returned word so rdata stays put between responses.
    always_ff @(posedge clk) begin
      if (reset) begin
        hold_reg <= '0;
      end else if (resp_valid[gi]) begin
        hold_reg <= bus.mem_rdata;
      end
    end

    assign resp_data[gi] = resp_valid[gi] ? bus.mem_rdata : hold_reg;
  end

  assign bus.imem_valid = resp_valid[0];
  assign bus.imem_rdata = resp_data[0];
  assign bus.dmem_valid = resp_valid[1];
  assign bus.dmem_rdata = resp_data[1];

endmodule
